// File: rtl/wide_word_unpacker.sv
// wide_word_unpacker
//
// Splits one wide packed word into N narrow chunks and replays them, most-significant chunk
// first, on a narrow valid/ready stream. The word is captured into a hold register on the
// input handshake. The first chunk is presented in the following cycle. When a new word is
// offered on the last beat, it is captured without an idle cycle between words.
//
// Parameters:
//   IN_W   width of the packed input word (integer multiple of OUT_W)
//   OUT_W  width of each output chunk
//   N      chunks per word (derived, IN_W/OUT_W, must be >= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    packed input word
//   in_valid   in_data is valid
//   in_ready   a word can be accepted this cycle (combinational from out_ready and rst)
//   out_data   current chunk (0 when not valid)
//   out_valid  out_data is valid
//   out_ready  consumer accepts the current chunk
//   out_last   current chunk is chunk N-1 of the word
//   out_idx    index of the current chunk, 0 = most-significant
//   out_par    (only with WIDE_UNPACK_PARITY_EN) even parity over out_data
//
// Optional feature macro: WIDE_UNPACK_PARITY_EN adds the out_par port.

`timescale 1ns / 1ps

module wide_word_unpacker #(
    parameter int IN_W  = 256,
    parameter int OUT_W = 64,
    localparam int N    = IN_W / OUT_W,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [IdxW-1:0]   out_idx
`ifdef WIDE_UNPACK_PARITY_EN
    ,
    output logic              out_par
`endif
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IN_W-1:0]   hold_q, hold_d;

    logic              is_send;
    logic              is_last;
    logic              accept_in;
    logic              beat;
    logic [OUT_W-1:0]  chunk;

    // ------------------------------------------------------------------
    // Status and handshakes
    // ------------------------------------------------------------------
    assign is_send   = (state_q == StSend);
    assign is_last   = is_send && (idx_q == LastIdx);
    assign beat      = is_send && out_ready;
    // A new word is accepted when idle, or on the final beat so words stream without a bubble.
    assign in_ready  = !rst && (!is_send || (is_last && out_ready));
    assign accept_in = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Chunk select: chunk i occupies hold[IN_W-1-i*OUT_W -: OUT_W]
    // ------------------------------------------------------------------
    always_comb begin
        chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IdxW'(i)) begin
                chunk = hold_q[IN_W-1-i*OUT_W -: OUT_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: driven only from registered state, so they hold under backpressure
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = is_send;
        out_last  = is_last;
        out_idx   = is_send ? idx_q : '0;
        out_data  = is_send ? chunk : '0;
    end

`ifdef WIDE_UNPACK_PARITY_EN
    assign out_par = ^out_data;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;

        unique case (state_q)
            StIdle: begin
                if (accept_in) begin
                    hold_d  = in_data;
                    idx_d   = '0;
                    state_d = StSend;
                end
            end

            StSend: begin
                if (beat) begin
                    if (!is_last) begin
                        idx_d = idx_q + IdxW'(1);
                    end else if (accept_in) begin
                        // Back-to-back word: restart at chunk 0 without leaving StSend.
                        hold_d = in_data;
                        idx_d  = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    a_idx_bound : assert property (@(posedge clk) disable iff (rst) idx_q <= LastIdx);

    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_idx)));
`endif

endmodule

// File: tb/tb_wide_word_unpacker.sv
`timescale 1ns / 1ps

module tb_wide_word_unpacker;

    localparam int IN_W  = 256;
    localparam int OUT_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [1:0]        out_idx;
`ifdef WIDE_UNPACK_PARITY_EN
    logic              out_par;
`endif

    wide_word_unpacker #(
        .IN_W (IN_W),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .out_idx  (out_idx)
`ifdef WIDE_UNPACK_PARITY_EN
        ,
        .out_par  (out_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    beat_cyc[$];
    logic  beat_rdy[$];
    int    checks = 0;
    int    errors = 0;
    int    beats  = 0;
    int    cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic push_chunks(input logic [63:0] c0, input logic [63:0] c1,
                               input logic [63:0] c2, input logic [63:0] c3, input int npush);
        logic [63:0] c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int i = 0; i < npush; i++) begin
            exp_q.push_back('{data: c[i], idx: 2'(i), last: (i == 3)});
        end
    endtask

    // Offers {c0,c1,c2,c3}; returns 1 ns after the accepting clock edge with in_valid low.
    task automatic offer(input logic [63:0] c0, input logic [63:0] c1,
                         input logic [63:0] c2, input logic [63:0] c3, input int npush);
        bit ok = 1'b0;
        in_data  = {c0, c1, c2, c3};
        in_valid = 1'b1;
        push_chunks(c0, c1, c2, c3, npush);
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on each output handshake
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            beats++;
            beat_cyc.push_back(cyc);
            beat_rdy.push_back(in_ready);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h idx %0d, expected no beat", out_data,
                         out_idx);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", out_data, e.data);
                check("beat_idx", 64'(out_idx), 64'(e.idx));
                check("beat_last", 64'(out_last), 64'(e.last));
`ifdef WIDE_UNPACK_PARITY_EN
                check("beat_par", 64'(out_par), 64'(^e.data));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // T1 basic word
        b0 = beats;
        offer(64'h00000002_00000001, 64'h00000002_00000002,
              64'h00000002_00000001, 64'h00000002_00000001, 4);
        check("t1_latency_valid", 64'(out_valid), 64'd1);
        check("t1_latency_idx", 64'(out_idx), 64'd0);
        drain();
        check("t1_beats", 64'(beats - b0), 64'd4);

        // T2 back-to-back
        b0 = beats;
        beat_cyc.delete();
        beat_rdy.delete();
        check("t2_idle_ready", 64'(in_ready), 64'd1);
        offer(64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7,
              64'hC0C1C2C3C4C5C6C7, 64'hD0D1D2D3D4D5D6D7, 4);
        offer(64'h0000000000000001, 64'h8000000000000000,
              64'hFFFF0000FFFF0000, 64'h123456789ABCDEF0, 4);
        drain();
        check("t2_beats", 64'(beats - b0), 64'd8);
        if (beat_cyc.size() == 8) begin
            check("t2_no_bubble", 64'(beat_cyc[7] - beat_cyc[0]), 64'd7);
            for (int i = 0; i < 8; i++) begin
                check("t2_in_ready", 64'(beat_rdy[i]), 64'((i == 3) || (i == 7)));
            end
        end

        // T3 backpressure at idx 1
        b0 = beats;
        offer(64'h1111111111111111, 64'h2222222222222222,
              64'h3333333333333333, 64'h4444444444444444, 4);
        @(posedge clk);
        #1;
        check("t3_at_idx1", 64'(out_idx), 64'd1);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_idx", 64'(out_idx), 64'd1);
            check("t3_hold_data", out_data, 64'h2222222222222222);
            check("t3_hold_last", 64'(out_last), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        check("t3_beats", 64'(beats - b0), 64'd4);

        // T4 reset mid-word: only chunks 0 and 1 may ever appear
        offer(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t4_async_valid", 64'(out_valid), 64'd0);
        check("t4_async_in_ready", 64'(in_ready), 64'd0);
        check("t4_async_data", out_data, 64'd0);
        check("t4_async_idx", 64'(out_idx), 64'd0);
        check("t4_sb_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        b0 = beats;
        @(negedge clk);
        check("t4_release_in_ready", 64'(in_ready), 64'd1);
        check("t4_release_valid", 64'(out_valid), 64'd0);
        repeat (6) @(negedge clk);
        check("t4_no_stale", 64'(beats - b0), 64'd0);
        @(posedge clk);
        #1;

        // T5 input stall: word B held during beats of word A
        offer(64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
              64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 4);
        in_data  = {64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA,
                    64'h0000000100000002, 64'h8000000000000001};
        in_valid = 1'b1;
        push_chunks(64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA,
                    64'h0000000100000002, 64'h8000000000000001, 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        @(negedge clk);
        check("t5_last_noready", 64'(in_ready), 64'd0);
        check("t5_last_flag", 64'(out_last), 64'd1);
        @(posedge clk);
        #1;
        check("t5_not_captured_idx", 64'(out_idx), 64'd3);
        check("t5_not_captured_data", out_data, 64'hF0F0F0F0F0F0F0F0);
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_last_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t5_new_idx", 64'(out_idx), 64'd0);
        check("t5_new_data", out_data, 64'h5555555555555555);
        drain();

`ifdef WIDE_UNPACK_PARITY_EN
        // T6 parity
        offer(64'h00000002_00000001, 64'h00000002_00000003,
              64'h0000000000000000, 64'h0000000000000007, 4);
        check("t6_par_even", 64'(out_par), 64'd0);
        @(posedge clk);
        #1;
        check("t6_par_odd", 64'(out_par), 64'd1);
        drain();
        check("t6_par_idle", 64'(out_par), 64'd0);
`endif

        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
